// File: rtl/part_sram_sync_if.sv
// rtl/part_sram_sync_if.sv - access bus for part_sram_sync
interface part_sram_sync_if #(
    parameter int WIDTH = 1,
    parameter int AW    = 10
);
    logic             ce_n;
    logic             we_n;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] di;
    logic [WIDTH-1:0] dout;
    logic             rd_valid;
    logic             busy;
    logic             parity_err;

    modport master (
        output ce_n, we_n, addr, di,
        input  dout, rd_valid, busy, parity_err
    );

    modport slave (
        input  ce_n, we_n, addr, di,
        output dout, rd_valid, busy, parity_err
    );
endinterface

// File: rtl/part_sram_sync.sv
// rtl/part_sram_sync.sv - synchronous RAM with clear sweep after reset; RAM_PARITY_EN adds per-word even parity
module part_sram_sync #(
    parameter int               WIDTH      = 1,
    parameter int               DEPTH      = 1024,
    parameter int               AW         = 10,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    part_sram_sync_if.slave bus
);
    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q;
    logic             addr_ok;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic             rd_en;

    logic [WIDTH-1:0] mem [DEPTH];

    // An X/Z address makes this compare unknown, which the if-statements below treat as out of range.
    assign addr_ok = ({1'b0, bus.addr} < DEPTH_W);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_CLEAR;
            cnt_q    <= '0;
            bus.busy <= 1'b1;
        end else begin
            state_q  <= state_d;
            bus.busy <= (state_d == ST_CLEAR);
            if (state_q == ST_CLEAR) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = INIT_VALUE;
        rd_en     = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (!bus.ce_n) begin
                    if (!bus.we_n) begin
                        mem_waddr = bus.addr;
                        mem_wdata = bus.di;
                        if (addr_ok) begin
                            mem_we = 1'b1;
                        end
                    end else begin
                        rd_en = 1'b1;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

`ifdef RAM_PARITY_EN
    logic          par_mem [DEPTH];
    logic          inj_tog;
    logic          inj_seen;
    logic [AW-1:0] inj_addr;

    // Test hook: flips the stored parity bit of one word at the next clock edge.
    task automatic inject_error(input logic [AW-1:0] a);
        inj_addr = a;
        inj_tog  = (inj_tog === 1'b1) ? 1'b0 : 1'b1;
    endtask

    always_ff @(posedge clk) begin
        inj_seen <= inj_tog;
        if (reset_n && mem_we) begin
            mem[mem_waddr]     <= mem_wdata;
            par_mem[mem_waddr] <= ^mem_wdata;
        end
        if (inj_tog != inj_seen) begin
            par_mem[inj_addr] <= ~par_mem[inj_addr];
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset_n && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.dout       <= '0;
            bus.rd_valid   <= 1'b0;
            bus.parity_err <= 1'b0;
        end else begin
            bus.rd_valid <= rd_en;
            if (rd_en) begin
                if (addr_ok) begin
                    bus.dout <= mem[bus.addr];
`ifdef RAM_PARITY_EN
                    bus.parity_err <= (^mem[bus.addr]) ^ par_mem[bus.addr];
`else
                    bus.parity_err <= 1'b0;
`endif
                end else begin
                    bus.dout       <= '0;
                    bus.parity_err <= 1'b0;
                end
            end
        end
    end
endmodule
